// File: rtl/onehot_sched_pkg.sv
// -----------------------------------------------------------------------------
// onehot_sched_pkg
//   Shared definitions for the one-hot round-robin scheduler:
//     N_REQ    - default number of requesters
//     IDX_W    - default width of the binary grant index
//     state_e  - scheduler FSM states
//     next_ptr - round-robin pointer advance with mod-n wrap
// -----------------------------------------------------------------------------
package onehot_sched_pkg;

  localparam int unsigned N_REQ = 15;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Pointer to the slot after idx, wrapping from n-1 back to 0.
  function automatic int unsigned next_ptr(input int unsigned idx,
                                           input int unsigned n);
    if (idx + 1 >= n) begin
      return 0;
    end
    return idx + 1;
  endfunction

endpackage

// File: rtl/onehot_rr_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin search: finds the first set bit of req,
//   scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//   Ports:
//     req   [N]      - request vector
//     ptr   [IDX_W]  - position where the search starts
//     found          - at least one request is set
//     idx   [IDX_W]  - index of the winner; 0 when found=0
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int unsigned N     = 15,
  parameter int unsigned IDX_W = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] base;
  logic [IDX_W:0]   pos;

  always_comb begin
    // An out-of-range pointer restarts the scan at 0 rather than skipping slots.
    base  = (32'(ptr) < N) ? ptr : '0;
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      // base + off < 2N, so one conditional subtract gives the mod-N position.
      pos = {1'b0, base} + (IDX_W+1)'(off);
      if (pos >= (IDX_W+1)'(N)) begin
        pos = pos - (IDX_W+1)'(N);
      end
      if (!found && req[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/onehot_rr_sched.sv
// -----------------------------------------------------------------------------
// onehot_rr_sched
//   Round-robin scheduler sharing one resource among N requesters. A winner
//   is picked in IDLE, holds the grant in GRANT until it signals done, drops
//   its request, or reaches MAX_HOLD cycles, then one dead RELEASE cycle
//   lets the resource drain before the next arbitration.
//   Ports:
//     clk        - clock, rising edge
//     rst        - asynchronous, active-high reset
//     req   [N]  - level requests, held until granted
//     done       - grantee finished; only looked at in GRANT
//     gnt   [N]  - one-hot grant, all-zero when idle
//     gnt_valid  - high exactly when gnt is non-zero
//     gnt_idx    - binary index of the grantee, 0 when gnt_valid=0
//     timeout    - one-cycle pulse coincident with a forced release
// -----------------------------------------------------------------------------
module onehot_rr_sched #(
  parameter int unsigned N        = onehot_sched_pkg::N_REQ,
  parameter int unsigned IDX_W    = onehot_sched_pkg::IDX_W,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             timeout
);

  import onehot_sched_pkg::*;

  state_e           state_q,     state_d;
  logic [IDX_W-1:0] ptr_q,       ptr_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [IDX_W-1:0] gnt_idx_q,   gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q,   timeout_d;
  logic [N-1:0]     gnt_q,       gnt_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  logic             own_req;
  logic             hold_expired;

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign own_req      = req[gnt_idx_q];
  assign hold_expired = (cnt_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          cnt_d       = '0;
          ptr_d       = IDX_W'(next_ptr(32'(pick_idx), N));
        end else begin
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
        end
      end

      GRANT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (done || !own_req || hold_expired) begin
          state_d     = RELEASE;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          cnt_d       = '0;
          // done and a dropped request both outrank the hold limit, so the
          // pulse only marks releases forced purely by the counter.
          timeout_d   = !done && own_req && hold_expired;
        end
      end

      RELEASE: begin
        state_d     = IDLE;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
      end

      default: begin
        state_d     = IDLE;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  // One-hot decode from the next-state index/valid, registered alongside
  // them so gnt lines up with gnt_idx/gnt_valid and cannot glitch.
  always_comb begin
    gnt_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      gnt_d[i] = gnt_valid_d && (gnt_idx_d == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      gnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      gnt_q       <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_onehot_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_onehot_rr_sched
//   Directed bench for onehot_rr_sched: reset, rotation, single requester,
//   pointer skip, timeout and simultaneous release events.
// -----------------------------------------------------------------------------
module tb_onehot_rr_sched;

  localparam int unsigned N        = 15;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned MAX_HOLD = 16;
  localparam int unsigned CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     gnt;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  onehot_rr_sched #(
    .N        (N),
    .IDX_W    (IDX_W),
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle;
    req  = '0;
    done = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    repeat (2) tick();
    tests++;
    if ({gnt, gnt_valid, gnt_idx, timeout} !== '0) begin
      $display("FAIL reset_outputs: got gnt=%h v=%b idx=%0d to=%b exp all 0",
               gnt, gnt_valid, gnt_idx, timeout);
      fails++;
    end
    rst = 1'b0;
    tick();
    req = 15'h0004;
    tick();
    tests++;
    if (gnt !== 15'h0004 || gnt_idx !== 4'd2 || gnt_valid !== 1'b1) begin
      $display("FAIL reset_pregrant: got gnt=%h idx=%0d v=%b exp gnt=0004 idx=2 v=1",
               gnt, gnt_idx, gnt_valid);
      fails++;
    end
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if (gnt !== '0 || gnt_valid !== 1'b0 || gnt_idx !== '0) begin
      $display("FAIL reset_async: got gnt=%h v=%b idx=%0d exp 0 before edge",
               gnt, gnt_valid, gnt_idx);
      fails++;
    end
    req = 15'h7FFF;
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (gnt !== 15'h0001 || gnt_idx !== 4'd0 || gnt_valid !== 1'b1) begin
      $display("FAIL reset_ptr0: got gnt=%h idx=%0d v=%b exp gnt=0001 idx=0 v=1",
               gnt, gnt_idx, gnt_valid);
      fails++;
    end
    go_idle();
  endtask

  task automatic test_rotation;
    logic [N-1:0]     exp_gnt;
    logic [IDX_W-1:0] exp_idx;
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    req  = 15'h7FFF;
    done = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      exp_idx          = IDX_W'(i % 15);
      exp_gnt          = '0;
      exp_gnt[exp_idx] = 1'b1;
      tests++;
      if (gnt_idx !== exp_idx || gnt !== exp_gnt || gnt_valid !== 1'b1) begin
        $display("FAIL rotation[%0d]: got idx=%0d gnt=%h v=%b exp idx=%0d gnt=%h v=1",
                 i, gnt_idx, gnt, gnt_valid, exp_idx, exp_gnt);
        fails++;
      end
      tick();
      tests++;
      if (gnt !== '0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
        $display("FAIL rotation_gap[%0d]: got gnt=%h v=%b to=%b exp 0",
                 i, gnt, gnt_valid, timeout);
        fails++;
      end
      repeat (2) tick();
    end
    go_idle();
  endtask

  task automatic test_single;
    req = 15'h0020;
    tick();
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (gnt !== 15'h0020 || gnt_idx !== 4'd5 || gnt_valid !== 1'b1) begin
        $display("FAIL single_hold[%0d]: got gnt=%h idx=%0d v=%b exp gnt=0020 idx=5 v=1",
                 c, gnt, gnt_idx, gnt_valid);
        fails++;
      end
      if (c == 3) done = 1'b1;
      tick();
    end
    done = 1'b0;
    tests++;
    if (gnt !== '0 || gnt_valid !== 1'b0 || gnt_idx !== '0 || timeout !== 1'b0) begin
      $display("FAIL single_release: got gnt=%h v=%b idx=%0d to=%b exp 0",
               gnt, gnt_valid, gnt_idx, timeout);
      fails++;
    end
    tick();
    tests++;
    if (gnt !== '0 || gnt_valid !== 1'b0) begin
      $display("FAIL single_idle: got gnt=%h v=%b exp 0", gnt, gnt_valid);
      fails++;
    end
    tick();
    tests++;
    if (gnt !== 15'h0020 || gnt_idx !== 4'd5) begin
      $display("FAIL single_regrant: got gnt=%h idx=%0d exp gnt=0020 idx=5",
               gnt, gnt_idx);
      fails++;
    end
    go_idle();
  endtask

  task automatic test_pointer_skip;
    req = 15'h0041;
    tick();
    tests++;
    if (gnt_idx !== 4'd6 || gnt !== 15'h0040) begin
      $display("FAIL skip_first: got idx=%0d gnt=%h exp idx=6 gnt=0040", gnt_idx, gnt);
      fails++;
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (2) tick();
    tests++;
    if (gnt_idx !== 4'd0 || gnt !== 15'h0001) begin
      $display("FAIL skip_wrap: got idx=%0d gnt=%h exp idx=0 gnt=0001", gnt_idx, gnt);
      fails++;
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (2) tick();
    tests++;
    if (gnt_idx !== 4'd6 || gnt !== 15'h0040) begin
      $display("FAIL skip_back: got idx=%0d gnt=%h exp idx=6 gnt=0040", gnt_idx, gnt);
      fails++;
    end
    go_idle();
  endtask

  task automatic test_timeout;
    req = 15'h0100;
    tick();
    for (int c = 0; c < 16; c++) begin
      tests++;
      if (gnt !== 15'h0100 || gnt_idx !== 4'd8 || timeout !== 1'b0) begin
        $display("FAIL timeout_hold[%0d]: got gnt=%h idx=%0d to=%b exp gnt=0100 idx=8 to=0",
                 c, gnt, gnt_idx, timeout);
        fails++;
      end
      tick();
    end
    tests++;
    if (gnt !== '0 || gnt_valid !== 1'b0 || timeout !== 1'b1) begin
      $display("FAIL timeout_pulse: got gnt=%h v=%b to=%b exp gnt=0 v=0 to=1",
               gnt, gnt_valid, timeout);
      fails++;
    end
    tick();
    tests++;
    if (gnt !== '0 || timeout !== 1'b0) begin
      $display("FAIL timeout_single: got gnt=%h to=%b exp gnt=0 to=0", gnt, timeout);
      fails++;
    end
    go_idle();
  endtask

  task automatic test_simultaneous;
    req = 15'h0100;
    tick();
    for (int c = 0; c < 16; c++) begin
      tests++;
      if (gnt !== 15'h0100) begin
        $display("FAIL simul_hold[%0d]: got gnt=%h exp 0100", c, gnt);
        fails++;
      end
      if (c == 15) done = 1'b1;
      tick();
    end
    done = 1'b0;
    tests++;
    if (gnt !== '0 || timeout !== 1'b0) begin
      $display("FAIL simul_done_wins: got gnt=%h to=%b exp gnt=0 to=0", gnt, timeout);
      fails++;
    end
    go_idle();

    req = 15'h0003;
    tick();
    tests++;
    if (gnt_idx !== 4'd0 || gnt !== 15'h0001) begin
      $display("FAIL drop_first: got idx=%0d gnt=%h exp idx=0 gnt=0001", gnt_idx, gnt);
      fails++;
    end
    req = 15'h0002;
    tick();
    tests++;
    if (gnt !== '0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      $display("FAIL drop_release: got gnt=%h v=%b to=%b exp 0", gnt, gnt_valid, timeout);
      fails++;
    end
    repeat (2) tick();
    tests++;
    if (gnt_idx !== 4'd1 || gnt !== 15'h0002) begin
      $display("FAIL drop_next: got idx=%0d gnt=%h exp idx=1 gnt=0002", gnt_idx, gnt);
      fails++;
    end
    go_idle();
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    test_reset();
    test_rotation();
    test_single();
    test_pointer_skip();
    test_timeout();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
